// File: rtl/seg7_scan_controller_pkg.sv
// rtl/seg7_scan_controller_pkg.sv - shared constants, FSM enum and BCD helper
//
// Purpose: common definitions for the 4-digit display scan controller and
//          its serial binary-to-BCD converter.
// Contents: BLANK_CODE, NUM_DIGITS, MAX_DISP, conv_state_t,
//           dd_adjust() (double-dabble add-3 step on a 16-bit BCD scratch).

package seg7_scan_controller_pkg;

  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam int          NUM_DIGITS = 4;
  localparam logic [31:0] MAX_DISP   = 32'd9999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } conv_state_t;

  // Any BCD digit of 5 or more gets +3 so the following left shift carries
  // correctly into the next decade.
  function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    logic [3:0]  nib;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = bcd[i*4 +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      res[i*4 +: 4] = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_controller_bin2bcd_seq.sv
// rtl/seg7_scan_controller_bin2bcd_seq.sv - serial double-dabble converter
//
// Purpose: converts a BIN_W-bit binary value to 4 BCD digits, one
//          shift-plus-add-3 iteration per clock, and flags values > 9999.
// Ports:
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset
//   start    in   capture value and begin (ignored unless IDLE)
//   value    in   binary value to convert
//   busy     out  high from the cycle after start through COMMIT
//   done     out  high only during the COMMIT cycle
//   over     out  captured value exceeded 9999 (held until next start)
//   bcd      out  16-bit BCD result, valid while done is high

module bin2bcd_seq
  import seg7_scan_controller_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             over,
  output logic [15:0]      bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state;
  logic [BIN_W-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic [15:0]      adj;

  assign adj = dd_adjust(bcd);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      over  <= 1'b0;
      shreg <= '0;
      count <= '0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CONVERT;
            busy  <= 1'b1;
            shreg <= value;
            count <= '0;
            bcd   <= '0;
            over  <= (32'(value) > MAX_DISP);
          end
        end
        CONVERT: begin
          // MSB of the binary operand shifts into the adjusted scratch.
          bcd   <= (adj << 1) | 16'(shreg[BIN_W-1]);
          shreg <= shreg << 1;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(BIN_W - 1)) begin
            state <= COMMIT;
            done  <= 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - 4-digit multiplexed 7-segment scan sequencer
//
// Purpose: accepts a binary value, converts it to BCD, commits it to a
//          display register and time-multiplexes the shared decoder across
//          four common-anode digits with optional leading-zero blanking.
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   load        in   single-cycle convert-and-display request
//   value       in   binary value sampled when load is accepted
//   display_en  in   1 = scan active, 0 = all digits dark
//   busy        out  conversion in progress (load ignored)
//   done        out  one-cycle pulse in the commit cycle
//   ovf         out  last accepted value was above 9999
//   act_D       out  decoder update enable
//   addr        out  BCD code to decoder, 4'hF = blank
//   an_n        out  active-low one-hot anode select, bit 0 = units

module seg7_scan_controller
  import seg7_scan_controller_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int CLK_DIV  = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  input  logic             display_en,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             act_D,
  output logic [3:0]       addr,
  output logic [3:0]       an_n
);

  localparam int PS_W = $clog2(CLK_DIV);

  logic [15:0]     conv_bcd;
  logic            conv_over;
  logic [15:0]     disp;
  logic [PS_W-1:0] ps;
  logic            tick;
  logic [1:0]      idx;
  logic [1:0]      idx_d1;
  logic            en_d1;
  logic [3:0]      nz;
  logic [3:0]      any_above;
  logic [3:0]      digit;
  logic [3:0]      code;

  bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (load),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .over    (conv_over),
    .bcd     (conv_bcd)
  );

  // Display register only changes in the commit cycle, so the scan never
  // sees a half-converted value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp <= '0;
      ovf  <= 1'b0;
    end else if (done) begin
      disp <= conv_over ? {4{BLANK_CODE}} : conv_bcd;
      ovf  <= conv_over;
    end
  end

  assign tick = (ps == PS_W'(CLK_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps  <= '0;
      idx <= '0;
    end else if (!display_en) begin
      ps  <= '0;
      idx <= '0;
    end else if (tick) begin
      ps  <= '0;
      idx <= idx + 2'd1;
    end else begin
      ps  <= ps + PS_W'(1);
    end
  end

  // any_above[i] = some digit at position i or higher is nonzero.
  assign nz        = {|disp[15:12], |disp[11:8], |disp[7:4], |disp[3:0]};
  assign any_above = {nz[3], |nz[3:2], |nz[3:1], |nz[3:0]};
  assign digit     = disp[{idx, 2'b00} +: 4];

  always_comb begin
    code = digit;
    if ((BLANK_LZ != 0) && (idx != 2'd0) && !any_above[idx]) code = BLANK_CODE;
  end

  // The decoder registers its segments, so the anode select is delayed one
  // cycle behind addr to switch on the same edge as the segment pattern.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_D  <= 1'b0;
      addr   <= BLANK_CODE;
      an_n   <= 4'b1111;
      idx_d1 <= '0;
      en_d1  <= 1'b0;
    end else begin
      act_D  <= display_en;
      addr   <= display_en ? code : BLANK_CODE;
      idx_d1 <= idx;
      en_d1  <= display_en;
      an_n   <= en_d1 ? ~(4'b0001 << idx_d1) : 4'b1111;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - directed self-checking bench for seg7_scan_controller

module tb_seg7_scan_controller;

  localparam int BIN_W   = 14;
  localparam int CLK_DIV = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             load;
  logic [BIN_W-1:0] value;
  logic             display_en;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             act_D;
  logic [3:0]       addr;
  logic [3:0]       an_n;

  int vectors = 0;
  int errors  = 0;

  seg7_scan_controller #(
    .BIN_W    (BIN_W),
    .CLK_DIV  (CLK_DIV),
    .BLANK_LZ (1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .value      (value),
    .display_en (display_en),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .act_D      (act_D),
    .addr       (addr),
    .an_n       (an_n)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Load a value and verify busy/done timing relative to the accepting edge.
  task automatic do_load(input logic [BIN_W-1:0] v, input string nm);
    value = v;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      vectors++;
      if (busy !== (c <= 15)) begin
        errors++;
        $display("FAIL %s busy cycle k+%0d: got %b expected %b", nm, c, busy, (c <= 15));
      end
      vectors++;
      if (done !== (c == 15)) begin
        errors++;
        $display("FAIL %s done cycle k+%0d: got %b expected %b", nm, c, done, (c == 15));
      end
      tick(1);
    end
  endtask

  // Sample a scan window; addr at cycle t must be the digit whose anode is
  // selected at cycle t+1, anodes rotate upward, each dwell is CLK_DIV cycles.
  task automatic check_scan(input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [3:0] e3,
                            input string nm);
    logic [3:0] a_s [24];
    logic [3:0] n_s [24];
    logic [3:0] exp_d [4];
    logic [3:0] nxt;
    int         di;
    int         last_tr;
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
    for (int t = 0; t < 24; t++) begin
      a_s[t] = addr;
      n_s[t] = an_n;
      vectors++;
      if (act_D !== 1'b1) begin
        errors++;
        $display("FAIL %s act_D t=%0d: got %b expected 1", nm, t, act_D);
      end
      tick(1);
    end
    for (int t = 0; t < 23; t++) begin
      case (n_s[t+1])
        4'b1110: di = 0;
        4'b1101: di = 1;
        4'b1011: di = 2;
        4'b0111: di = 3;
        default: di = -1;
      endcase
      vectors++;
      if (di < 0) begin
        errors++;
        $display("FAIL %s an_n t=%0d: got %b expected one-hot low", nm, t + 1, n_s[t+1]);
      end else if (a_s[t] !== exp_d[di]) begin
        errors++;
        $display("FAIL %s addr digit %0d t=%0d: got %h expected %h", nm, di, t, a_s[t], exp_d[di]);
      end
    end
    last_tr = -1;
    for (int t = 1; t < 24; t++) begin
      if (n_s[t] !== n_s[t-1]) begin
        nxt = {n_s[t-1][2:0], n_s[t-1][3]};
        vectors++;
        if (n_s[t] !== nxt) begin
          errors++;
          $display("FAIL %s an_n order t=%0d: got %b expected %b", nm, t, n_s[t], nxt);
        end
        if (last_tr >= 0) begin
          vectors++;
          if (t - last_tr != CLK_DIV) begin
            errors++;
            $display("FAIL %s dwell t=%0d: got %0d expected %0d", nm, t, t - last_tr, CLK_DIV);
          end
        end
        last_tr = t;
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    load       = 1'b0;
    value      = '0;
    display_en = 1'b0;
    tick(2);
    for (int pass = 0; pass < 2; pass++) begin
      vectors++;
      if (act_D !== 1'b0) begin errors++; $display("FAIL reset act_D: got %b expected 0", act_D); end
      vectors++;
      if (addr !== 4'hF) begin errors++; $display("FAIL reset addr: got %h expected f", addr); end
      vectors++;
      if (an_n !== 4'b1111) begin errors++; $display("FAIL reset an_n: got %b expected 1111", an_n); end
      vectors++;
      if ({busy, done, ovf} !== 3'b000) begin
        errors++;
        $display("FAIL reset busy/done/ovf: got %b expected 000", {busy, done, ovf});
      end
      if (pass == 0) begin
        reset_n = 1'b1;
        tick(3);
      end
    end
  endtask

  task automatic test_scan_zero();
    display_en = 1'b1;
    tick(3);
    check_scan(4'h0, 4'hF, 4'hF, 4'hF, "scan_zero");
  endtask

  task automatic test_load_1234();
    do_load(14'd1234, "load_1234");
    vectors++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL load_1234 ovf: got %b expected 0", ovf); end
    check_scan(4'h4, 4'h3, 4'h2, 4'h1, "scan_1234");
  endtask

  task automatic test_values();
    do_load(14'd7, "load_7");
    check_scan(4'h7, 4'hF, 4'hF, 4'hF, "scan_7");
    do_load(14'd0, "load_0");
    check_scan(4'h0, 4'hF, 4'hF, 4'hF, "scan_0");
    do_load(14'd1005, "load_1005");
    check_scan(4'h5, 4'h0, 4'h0, 4'h1, "scan_1005");
  endtask

  task automatic test_overflow();
    do_load(14'd10000, "load_10000");
    vectors++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_10000: got %b expected 1", ovf); end
    check_scan(4'hF, 4'hF, 4'hF, 4'hF, "scan_10000");
    do_load(14'd9999, "load_9999");
    vectors++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_9999: got %b expected 0", ovf); end
    check_scan(4'h9, 4'h9, 4'h9, 4'h9, "scan_9999");
  endtask

  task automatic test_ignored_loads();
    value = 14'd4321;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      vectors++;
      if (busy !== (c <= 15)) begin
        errors++;
        $display("FAIL ignore busy cycle k+%0d: got %b expected %b", c, busy, (c <= 15));
      end
      vectors++;
      if (done !== (c == 15)) begin
        errors++;
        $display("FAIL ignore done cycle k+%0d: got %b expected %b", c, done, (c == 15));
      end
      load = 1'b0;
      if (c == 4)  begin value = 14'd8888; load = 1'b1; end
      if (c == 15) begin value = 14'd5555; load = 1'b1; end
      tick(1);
    end
    load = 1'b0;
    check_scan(4'h1, 4'h2, 4'h3, 4'h4, "scan_4321");
  endtask

  task automatic test_reset_mid();
    value = 14'd5678;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL midrst pre busy/done k+%0d: got %b expected 10", c, {busy, done});
      end
      tick(1);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, ovf, act_D} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst busy/done/ovf/act_D: got %b expected 0000", {busy, done, ovf, act_D});
    end
    vectors++;
    if (addr !== 4'hF) begin errors++; $display("FAIL midrst addr: got %h expected f", addr); end
    vectors++;
    if (an_n !== 4'b1111) begin errors++; $display("FAIL midrst an_n: got %b expected 1111", an_n); end
    tick(2);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL midrst post busy/done c=%0d: got %b expected 00", c, {busy, done});
      end
      tick(1);
    end
    check_scan(4'h0, 4'hF, 4'hF, 4'hF, "scan_after_rst");
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_load_1234();
    test_values();
    test_overflow();
    test_ignored_loads();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
